// File: rtl/aes_sched_pkg.sv
// aes_sched_pkg
//   Shared definitions for the AES job scheduler: data width, fault
//   counter width, scheduler FSM state encoding and a saturating
//   increment helper used for the fault counter.
package aes_sched_pkg;

    localparam int AES_W  = 128;
    localparam int FCNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } sched_state_e;

    function automatic logic [FCNT_W-1:0] sat_inc(input logic [FCNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/aes_rr_arbiter.sv
// aes_rr_arbiter
//   Combinational round-robin arbiter. Searches the request vector
//   starting at ptr_i and wrapping, and grants the first active request.
// Ports:
//   req_i      N_REQ-wide request vector
//   ptr_i      index with highest priority this cycle
//   grant_o    one-hot grant (all zero when no request)
//   grant_id_o index of the granted requester
//   any_o      at least one request is active
module aes_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [ID_W-1:0]  grant_id_o,
    output logic             any_o
);

    always_comb begin
        logic [ID_W-1:0] idx;
        idx        = '0;
        grant_o    = '0;
        grant_id_o = '0;
        any_o      = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = ID_W'((32'(ptr_i) + k) % N_REQ);
            if (!any_o && req_i[idx]) begin
                any_o        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_id_o   = idx;
            end
        end
    end

endmodule

// File: rtl/aes_job_scheduler.sv
// aes_job_scheduler
//   Shares one AES-128 core between N_REQ requesters, one job at a time.
//   Jobs are granted round-robin, issued to the core, guarded by a
//   watchdog, retried up to MAX_RETRY times on a core fault alert and
//   answered with a one-cycle response pulse.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      per-requester handshake (ready is one-hot)
//   req_key/req_plaintext    per-requester operands, requester i at [i*128 +: 128]
//   core_start/key/plaintext command to the shared core
//   core_inject_fault        test hook, follows test_fault
//   core_ciphertext/valid/busy/fault_alert  core status
//   rsp_*                    response pulse, id, data and failure flags
//   fault_count              saturating count of failed jobs
module aes_job_scheduler
    import aes_sched_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 64,
    parameter int MAX_RETRY   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*AES_W-1:0]     req_key,
    input  logic [N_REQ*AES_W-1:0]     req_plaintext,
    output logic                       core_start,
    output logic [AES_W-1:0]           core_key,
    output logic [AES_W-1:0]           core_plaintext,
    output logic                       core_inject_fault,
    input  logic                       test_fault,
    input  logic [AES_W-1:0]           core_ciphertext,
    input  logic                       core_valid,
    input  logic                       core_busy,
    input  logic                       core_fault_alert,
    output logic                       rsp_valid,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [AES_W-1:0]           rsp_ciphertext,
    output logic                       rsp_fault,
    output logic                       rsp_timeout,
    output logic [FCNT_W-1:0]          fault_count
);

    localparam int ID_W = $clog2(N_REQ);
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam int RT_W = $clog2(MAX_RETRY + 2);

    sched_state_e       state_q;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    id_q;
    logic [AES_W-1:0]   key_q, pt_q;
    logic [WD_W-1:0]    wdog_q;
    logic [RT_W-1:0]    retry_q;
    logic               core_start_q;
    logic               rsp_valid_q, rsp_fault_q, rsp_timeout_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [AES_W-1:0]   rsp_ct_q;
    logic [FCNT_W-1:0]  fault_cnt_q, fault_cnt_d;

    logic [N_REQ-1:0]   grant;
    logic [ID_W-1:0]    grant_id;
    logic               grant_any;
    logic [AES_W-1:0]   sel_key, sel_pt;

    aes_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req_i      (req_valid),
        .ptr_i      (rr_ptr_q),
        .grant_o    (grant),
        .grant_id_o (grant_id),
        .any_o      (grant_any)
    );

    // One-hot grant makes an AND-OR mux sufficient for operand selection.
    always_comb begin
        sel_key = '0;
        sel_pt  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            sel_key = sel_key | (req_key[k*AES_W +: AES_W]       & {AES_W{grant[k]}});
            sel_pt  = sel_pt  | (req_plaintext[k*AES_W +: AES_W] & {AES_W{grant[k]}});
        end
    end

    assign rr_ptr_d    = ID_W'((32'(grant_id) + 1) % N_REQ);
    assign fault_cnt_d = sat_inc(fault_cnt_q);

    // Accept is combinational so a held req_valid is taken in the same IDLE cycle.
    assign req_ready         = (state_q == ST_IDLE && !rst) ? grant : '0;
    assign core_inject_fault = test_fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            id_q          <= '0;
            key_q         <= '0;
            pt_q          <= '0;
            wdog_q        <= '0;
            retry_q       <= '0;
            core_start_q  <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_fault_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_id_q      <= '0;
            rsp_ct_q      <= '0;
            fault_cnt_q   <= '0;
        end else begin
            core_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_any) begin
                        id_q     <= grant_id;
                        key_q    <= sel_key;
                        pt_q     <= sel_pt;
                        rr_ptr_q <= rr_ptr_d;
                        retry_q  <= '0;
                        wdog_q   <= '0;
                        state_q  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!core_busy) begin
                        core_start_q <= 1'b1;
                        wdog_q       <= '0;
                        state_q      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (core_fault_alert) begin
                        if (retry_q < RT_W'(MAX_RETRY)) begin
                            retry_q <= retry_q + 1'b1;
                            wdog_q  <= '0;
                            state_q <= ST_ISSUE;
                        end else begin
                            rsp_valid_q   <= 1'b1;
                            rsp_fault_q   <= 1'b1;
                            rsp_timeout_q <= 1'b0;
                            rsp_ct_q      <= '0;
                            rsp_id_q      <= id_q;
                            fault_cnt_q   <= fault_cnt_d;
                            state_q       <= ST_RESP;
                        end
                    end else if (core_valid) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_fault_q   <= 1'b0;
                        rsp_timeout_q <= 1'b0;
                        rsp_ct_q      <= core_ciphertext;
                        rsp_id_q      <= id_q;
                        state_q       <= ST_RESP;
                    end else if (wdog_q == WD_W'(TIMEOUT_CYC - 1)) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_fault_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_ct_q      <= '0;
                        rsp_id_q      <= id_q;
                        fault_cnt_q   <= fault_cnt_d;
                        state_q       <= ST_RESP;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    rsp_valid_q   <= 1'b0;
                    rsp_fault_q   <= 1'b0;
                    rsp_timeout_q <= 1'b0;
                    rsp_ct_q      <= '0;
                    rsp_id_q      <= '0;
                    state_q       <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign core_start     = core_start_q;
    assign core_key       = key_q;
    assign core_plaintext = pt_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_id         = rsp_id_q;
    assign rsp_ciphertext = rsp_ct_q;
    assign rsp_fault      = rsp_fault_q;
    assign rsp_timeout    = rsp_timeout_q;
    assign fault_count    = fault_cnt_q;

endmodule

// File: tb/tb_aes_job_scheduler.sv
// tb_aes_job_scheduler
//   Directed bench for aes_job_scheduler with a behavioural core model
//   (fixed latency of 2 cycles, optional silent / valid+fault modes).
module tb_aes_job_scheduler;

    localparam logic [127:0] K_FIPS  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P_FIPS  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_FIPS  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K_AES   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P_AES   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam int           LAT     = 2;
    localparam int           TO_CYC  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req_valid;
    logic [3:0]    req_ready;
    logic [511:0]  req_key, req_plaintext;
    logic          core_start;
    logic [127:0]  core_key, core_plaintext;
    logic          core_inject_fault;
    logic          test_fault;
    logic [127:0]  core_ciphertext = '0;
    logic          core_valid = 1'b0;
    logic          core_busy = 1'b0;
    logic          core_fault_alert = 1'b0;
    logic          rsp_valid;
    logic [1:0]    rsp_id;
    logic [127:0]  rsp_ciphertext;
    logic          rsp_fault, rsp_timeout;
    logic [7:0]    fault_count;

    int            n_vec = 0;
    int            n_err = 0;

    // core model controls: 0 normal, 1 never responds, 2 valid+fault on start number both_at
    int            core_mode = 0;
    int            both_at = -1;
    logic          busy_force = 1'b0;
    int            n_start = 0;
    int            cnt = 0;
    logic [127:0]  mk = '0, mp = '0;

    logic [1:0]    r_id;
    logic [127:0]  r_ct;
    logic          r_fault, r_to;
    logic [127:0]  KV [4];
    logic [127:0]  PV [4];

    aes_job_scheduler #(
        .N_REQ       (4),
        .TIMEOUT_CYC (TO_CYC),
        .MAX_RETRY   (1)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_key           (req_key),
        .req_plaintext     (req_plaintext),
        .core_start        (core_start),
        .core_key          (core_key),
        .core_plaintext    (core_plaintext),
        .core_inject_fault (core_inject_fault),
        .test_fault        (test_fault),
        .core_ciphertext   (core_ciphertext),
        .core_valid        (core_valid),
        .core_busy         (core_busy),
        .core_fault_alert  (core_fault_alert),
        .rsp_valid         (rsp_valid),
        .rsp_id            (rsp_id),
        .rsp_ciphertext    (rsp_ciphertext),
        .rsp_fault         (rsp_fault),
        .rsp_timeout       (rsp_timeout),
        .fault_count       (fault_count)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] model_ct(input logic [127:0] k, input logic [127:0] p);
        if (k == K_FIPS && p == P_FIPS) return C_FIPS;
        return k ^ p ^ {4{32'hA5A5A5A5}};
    endfunction

    always @(negedge clk) begin
        core_valid       = 1'b0;
        core_fault_alert = 1'b0;
        if (core_start) begin
            n_start = n_start + 1;
            cnt     = LAT;
            mk      = core_key;
            mp      = core_plaintext;
        end else if (cnt > 0) begin
            cnt = cnt - 1;
            if (cnt == 0 && core_mode != 1) begin
                if (core_inject_fault) begin
                    core_fault_alert = 1'b1;
                end else if (core_mode == 2 && n_start == both_at) begin
                    core_valid       = 1'b1;
                    core_fault_alert = 1'b1;
                    core_ciphertext  = model_ct(mk, mp);
                end else begin
                    core_valid      = 1'b1;
                    core_ciphertext = model_ct(mk, mp);
                end
            end
        end
        core_busy = busy_force || (cnt > 0);
    end

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raise req_valid[id], hold it until accepted, drop it right after the accept edge.
    task automatic request(input int id, input logic [127:0] k, input logic [127:0] p, output int ok);
        ok = 0;
        req_key[id*128 +: 128]       = k;
        req_plaintext[id*128 +: 128] = p;
        req_valid[id]                = 1'b1;
        #1;
        for (int i = 0; i < 50; i++) begin
            if (req_ready[id]) begin
                ok = 1;
                break;
            end
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1 req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(input int max, output int lat);
        lat = 0;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat     = i;
                r_id    = rsp_id;
                r_ct    = rsp_ciphertext;
                r_fault = rsp_fault;
                r_to    = rsp_timeout;
                break;
            end
        end
    endtask

    task automatic wait_grant(input int max, output int cyc);
        cyc = 0;
        #1;
        while (req_ready == '0 && cyc < max) begin
            @(negedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic wait_start(input int max, output int ok);
        ok = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (core_start) begin
                ok = 1;
                break;
            end
        end
    endtask

    initial begin
        int ok, lat, cyc, s0, seen;
        for (int i = 0; i < 4; i++) begin
            KV[i] = {16{8'(8'h11 * (i + 1))}};
            PV[i] = {16{8'(8'h0F + 8'h20 * i)}};
        end
        req_valid     = '0;
        req_key       = '0;
        req_plaintext = '0;
        test_fault    = 1'b0;
        rst           = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_rsp_valid", 128'(rsp_valid), 0);
        check_val("rst_core_start", 128'(core_start), 0);
        check_val("rst_fault_cnt", 128'(fault_count), 0);
        check_val("rst_core_key", core_key, 0);
        check_val("rst_rsp_ct", rsp_ciphertext, 0);
        rst = 1'b0;

        // FIPS-197 vector, minimum latency
        request(0, K_FIPS, P_FIPS, ok);
        check_val("t1_accept", 128'(ok), 1);
        wait_rsp(20, lat);
        check_val("t1_latency", 128'(lat), LAT + 3);
        check_val("t1_id", 128'(r_id), 0);
        check_val("t1_ct", r_ct, C_FIPS);
        check_val("t1_fault", 128'(r_fault), 0);
        check_val("t1_timeout", 128'(r_to), 0);

        // all four requesters at once from rr_ptr=0
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_key[i*128 +: 128]       = KV[i];
            req_plaintext[i*128 +: 128] = PV[i];
        end
        req_valid = 4'b1111;
        for (int j = 0; j < 4; j++) begin
            wait_grant(20, cyc);
            check_val("rr_grant", 128'(req_ready), 128'(1 << j));
            if (j > 0) check_val("b2b_grant_cyc", 128'(cyc), 1);
            @(posedge clk);
            #1 req_valid[j] = 1'b0;
            wait_rsp(20, lat);
            check_val("rr_rsp_id", 128'(r_id), 128'(j));
            check_val("rr_rsp_ct", r_ct, model_ct(KV[j], PV[j]));
        end
        req_valid = 4'b0011;
        wait_grant(20, cyc);
        check_val("wrap_grant0", 128'(req_ready), 128'h1);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        wait_rsp(20, lat);
        check_val("wrap_rsp_id0", 128'(r_id), 0);
        wait_grant(20, cyc);
        check_val("wrap_grant1", 128'(req_ready), 128'h2);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        wait_rsp(20, lat);
        check_val("wrap_rsp_id1", 128'(r_id), 1);

        // permanent injected fault: one retry then failure
        test_fault = 1'b1;
        s0 = n_start;
        request(2, K_AES, P_AES, ok);
        wait_rsp(40, lat);
        test_fault = 1'b0;
        check_val("flt_starts", 128'(n_start - s0), 2);
        check_val("flt_latency", 128'(lat), 9);
        check_val("flt_id", 128'(r_id), 2);
        check_val("flt_fault", 128'(r_fault), 1);
        check_val("flt_timeout", 128'(r_to), 0);
        check_val("flt_ct_zero", r_ct, 0);
        check_val("flt_count", 128'(fault_count), 1);

        // silent core: watchdog fires TO_CYC cycles after core_start
        core_mode = 1;
        s0 = n_start;
        request(3, KV[0], PV[0], ok);
        wait_start(10, ok);
        check_val("to_start_seen", 128'(ok), 1);
        wait_rsp(40, lat);
        core_mode = 0;
        check_val("to_latency", 128'(lat), TO_CYC);
        check_val("to_timeout", 128'(r_to), 1);
        check_val("to_fault", 128'(r_fault), 1);
        check_val("to_ct_zero", r_ct, 0);
        check_val("to_id", 128'(r_id), 3);
        check_val("to_starts", 128'(n_start - s0), 1);
        check_val("to_count", 128'(fault_count), 2);

        // valid and fault_alert together count as a fault, retry succeeds
        core_mode = 2;
        both_at   = n_start + 1;
        s0        = n_start;
        request(0, KV[1], PV[1], ok);
        wait_rsp(30, lat);
        core_mode = 0;
        check_val("both_starts", 128'(n_start - s0), 2);
        check_val("both_latency", 128'(lat), 9);
        check_val("both_fault", 128'(r_fault), 0);
        check_val("both_ct", r_ct, model_ct(KV[1], PV[1]));
        check_val("both_count", 128'(fault_count), 2);

        // core_busy holds ISSUE
        busy_force = 1'b1;
        @(negedge clk);
        s0 = n_start;
        request(1, KV[2], PV[2], ok);
        repeat (6) @(negedge clk);
        check_val("busy_no_start", 128'(n_start - s0), 0);
        busy_force = 1'b0;
        wait_rsp(20, lat);
        check_val("busy_starts", 128'(n_start - s0), 1);
        check_val("busy_id", 128'(r_id), 1);
        check_val("busy_ct", r_ct, model_ct(KV[2], PV[2]));

        // reset during WAIT drops the job
        request(2, KV[3], PV[3], ok);
        wait_start(10, ok);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("mid_rst_rsp_valid", 128'(rsp_valid), 0);
        check_val("mid_rst_core_start", 128'(core_start), 0);
        check_val("mid_rst_core_key", core_key, 0);
        check_val("mid_rst_core_pt", core_plaintext, 0);
        check_val("mid_rst_fault_cnt", 128'(fault_count), 0);
        check_val("mid_rst_req_ready", 128'(req_ready), 0);
        rst  = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check_val("mid_rst_no_rsp", 128'(seen), 0);
        request(0, K_FIPS, P_FIPS, ok);
        wait_rsp(20, lat);
        check_val("post_rst_latency", 128'(lat), LAT + 3);
        check_val("post_rst_id", 128'(r_id), 0);
        check_val("post_rst_ct", r_ct, C_FIPS);

        // fault_count saturation
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        test_fault = 1'b1;
        for (int i = 0; i < 255; i++) begin
            request(i % 4, KV[i % 4], PV[i % 4], ok);
            wait_rsp(40, lat);
        end
        check_val("sat_255", 128'(fault_count), 255);
        request(1, KV[1], PV[1], ok);
        wait_rsp(40, lat);
        check_val("sat_hold", 128'(fault_count), 255);
        check_val("sat_fault", 128'(r_fault), 1);
        test_fault = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes_job_scheduler.md
AES_JOB_SCHEDULER -- requirements
Module: aes_job_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one AES-128 core.
REQ-002 Parameter TIMEOUT_CYC, default 64, watchdog cycles allowed per core attempt.
REQ-003 Parameter MAX_RETRY, default 1, core re-issues allowed after fault_alert.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req_valid  in  N_REQ  per-requester job request, held until accepted.
REQ-007 req_ready  out  N_REQ  one-hot accept pulse; job taken when valid&ready.
REQ-008 req_key  in  N_REQ x 128  per-requester key.
REQ-009 req_plaintext  in  N_REQ x 128  per-requester plaintext.
REQ-010 core_start  out  1  one-cycle start pulse to shared core.
REQ-011 core_key, core_plaintext  out  128 each  operands to core, stable from start until job completes.
REQ-012 core_inject_fault  out  1  tied 0 in function; driven by test-only input test_fault (in, 1).
REQ-013 core_ciphertext  in  128; core_valid, core_busy, core_fault_alert  in  1 each  core status.
REQ-014 rsp_valid  out  1  one-cycle response pulse.
REQ-015 rsp_id  out  $clog2(N_REQ)  requester index of response.
REQ-016 rsp_ciphertext  out  128  result; all zeros when rsp_fault=1.
REQ-017 rsp_fault, rsp_timeout  out  1 each  job failed; failure cause was watchdog.
REQ-018 fault_count  out  8  saturating count of failed jobs.

Function
REQ-019 FSM states IDLE, ISSUE, WAIT, RESP; one job in flight at a time.
REQ-020 IDLE: if any req_valid, grant round-robin starting at rr_ptr, pulse req_ready[i], latch key/plaintext/id, clear retry and watchdog counters, go ISSUE.
REQ-021 rr_ptr = (granted id + 1) mod N_REQ, updated at grant; no requester starves beyond N_REQ-1 jobs.
REQ-022 ISSUE: if core_busy=1 hold; else assert core_start one cycle, go WAIT.
REQ-023 WAIT: watchdog increments each cycle from 0; priority fault_alert > valid > timeout.
REQ-024 core_fault_alert (including same cycle as core_valid): if retry<MAX_RETRY, retry++, watchdog=0, go ISSUE; else fail job, go RESP.
REQ-025 core_valid without fault: capture core_ciphertext, go RESP.
REQ-026 Watchdog reaching TIMEOUT_CYC-1 without valid/fault: fail job with rsp_timeout=1, no retry, go RESP.
REQ-027 RESP: rsp_valid=1 for exactly one cycle with rsp_id, data/flags; go IDLE; rsp outputs zero otherwise.
REQ-028 Failed job increments fault_count, saturating at 255.
REQ-029 Minimum latency req accept to rsp_valid = core latency + 3 cycles; back-to-back requests granted on the cycle after RESP.
REQ-030 req_valid deasserting after accept has no effect on the in-flight job.
REQ-031 core_valid/core_fault_alert outside WAIT are ignored.

Reset
REQ-032 rst on any edge, including mid-job, forces IDLE, rr_ptr=0, counters=0, fault_count=0, all outputs 0, in-flight job dropped with no response.
REQ-033 First grant possible on the cycle after rst deasserts.

Structure
REQ-034 Shared package aes_sched_pkg holds the state enum, AES_W=128 and the fault_count width.
REQ-035 One sub-module, aes_rr_arbiter (N_REQ-wide round-robin one-hot grant from req vector and pointer); the FSM stays in the top.

Verification
REQ-036 Req 0: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> rsp_id=0, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_fault=0.
REQ-037 Requesters 0-3 valid simultaneously, rr_ptr=0 -> responses in id order 0,1,2,3, then 0 again when re-requested.
REQ-038 test_fault=1 permanently, key 2b7e151628aed2a6abf7158809cf4f3c -> two core_start pulses, rsp_fault=1, zero data, fault_count=1.
REQ-039 Core model that never responds -> rsp_timeout=1 and rsp_fault=1 exactly TIMEOUT_CYC cycles after core_start.
REQ-040 core_valid and core_fault_alert asserted together -> treated as fault, retry issued.
REQ-041 rst asserted during WAIT -> no rsp_valid, all outputs 0 next cycle, subsequent job completes correctly.
